zpu_mem_responder: RTL

ZPU_MEM_RESPONDER -- requirements
Module: zpu_mem_responder

---
 rtl/zpu_mem_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/zpu_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zpu_mem_responder                                            |
// | Description : Single-port memory responder for a ZPU-style requester.      |
// |               The low half of the byte address space is a 32-bit word RAM  |
// |               with registered synchronous read. The high half is a small   |
// |               IO block: LED register, TIMER, ID constant and a reserved    |
// |               slot. Each transaction ends with a one-cycle mem_done pulse. |
// | Ports       : clk            - rising-edge clock                           |
// |               reset          - synchronous active-high reset               |
// |               mem_read       - read request, held until mem_done           |
// |               mem_write      - write request, held until mem_done          |
// |                                (wins when both requests are high)          |
// |               mem_addr       - byte address, bits [1:0] ignored            |
// |               mem_data_write - write data                                  |
// |               mem_data_read  - read data, valid in the mem_done cycle      |
// |               mem_done       - one-cycle completion pulse                  |
// |               leds           - LED register value                          |
// | Config      : ZPU_IO_TIMER_EN - when defined, TIMER is a 32-bit free-      |
// |               running counter (write loads 0). When undefined, TIMER       |
// |               reads 0, writes are ignored and no counter exists.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module zpu_mem_responder #(
  parameter int ADDR_W    = 10,
  parameter int RAM_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data_write,
  output logic [31:0]       mem_data_read,
  output logic              mem_done,
  output logic [4:0]        leds
);

  localparam int          RAM_IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] C_IO_ID   = 32'h5A50_0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAM_RD = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [4:0]           led_q, led_d;
  logic [31:0]          ram_q [RAM_WORDS];
  logic [31:0]          ram_rd_q;
  logic                 ram_we;
  logic                 ram_re;
  logic                 accept;
  logic                 is_io;
  logic [1:0]           io_off;
  logic [31:0]          word_mod;
  logic [RAM_IDX_W-1:0] ram_idx;
  logic [31:0]          timer_val;
  logic [31:0]          io_rdata;
  logic                 unused_bits;

  // Reset blocks acceptance so nothing (RAM, LED, TIMER) is touched on a reset edge.
  assign accept   = !reset && (state_q == IDLE) && (mem_read || mem_write);
  assign is_io    = mem_addr[ADDR_W-1];
  assign io_off   = mem_addr[3:2];
  assign word_mod = 32'(mem_addr[ADDR_W-2:2]) % 32'(RAM_WORDS);
  assign ram_idx  = word_mod[RAM_IDX_W-1:0];

  assign unused_bits = ^{mem_addr[1:0], word_mod};

`ifdef ZPU_IO_TIMER_EN
  logic [31:0] timer_q, timer_d;

  // A write to TIMER loads zero instead of incrementing that cycle.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (accept && mem_write && is_io && (io_off == 2'd1)) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer_val = timer_q;
`else
  assign timer_val = '0;
`endif

  always_comb begin
    io_rdata = '0;
    case (io_off)
      2'd0:    io_rdata = {27'd0, led_q};
      2'd1:    io_rdata = timer_val;
      2'd2:    io_rdata = C_IO_ID;
      default: io_rdata = '0;
    endcase
  end

  // Read data only moves on the edge that enters DONE for a read, so it holds
  // across writes and across the RAM_RD wait.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    led_d   = led_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_io) begin
            state_d = DONE;
            if (mem_write) begin
              if (io_off == 2'd0) begin
                led_d = mem_data_write[4:0];
              end
            end else begin
              rdata_d = io_rdata;
            end
          end else if (mem_write) begin
            ram_we  = 1'b1;
            state_d = DONE;
          end else begin
            ram_re  = 1'b1;
            state_d = RAM_RD;
          end
        end
      end
      RAM_RD: begin
        rdata_d = ram_rd_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
    end
  end

  // RAM contents survive reset; the read register is captured at accept so the
  // address may change freely while in RAM_RD.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= mem_data_write;
    end
    if (ram_re) begin
      ram_rd_q <= ram_q[ram_idx];
    end
  end

  assign mem_data_read = rdata_q;
  assign mem_done      = (state_q == DONE);
  assign leds          = led_q;

endmodule
`default_nettype wire
